// File: rtl/regfile_seq.sv
// regfile_seq: 31x32 register file plus sequencer that drives an external ALU.
// Operands are captured on start. The FSM then waits for the ALU: a fixed
// ALU_LAT for arithmetic and branch operations, or sl_ok followed by OUT_LAT
// for shifts. In WB it writes the result back, or latches the branch compare.
//
// Ports:
//   clk, reset (async, active-low)
//   start                  execute request, sampled only in IDLE
//   decinst_in[11:0]       {funct7[5], bit10, funct3, opcode}
//   rs1_sel, rs2_sel, rd_sel[4:0]  register indices
//   imm_in[31:0]           immediate
//   rs1, rs2, imm[31:0]    registered ALU operands
//   decinst[11:0]          registered instruction to the ALU (0 in IDLE)
//   en                     ALU shift enable
//   rd[31:0]               ALU result bus
//   sl_ok, cmp             ALU shift-done and branch-compare
//   busy, done, cmp_q      in progress, completion pulse, latched branch result
module regfile_seq #(
    parameter int unsigned ALU_LAT = 2,
    parameter int unsigned OUT_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] decinst_in,
    input  logic [4:0]  rs1_sel,
    input  logic [4:0]  rs2_sel,
    input  logic [4:0]  rd_sel,
    input  logic [31:0] imm_in,
    output logic [31:0] rs1,
    output logic [31:0] rs2,
    output logic [31:0] imm,
    output logic [11:0] decinst,
    output logic        en,
    input  logic [31:0] rd,
    input  logic        sl_ok,
    input  logic        cmp,
    output logic        busy,
    output logic        done,
    output logic        cmp_q
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned CW   = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_WAIT,
        S_WB
    } state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [RW-1:0]     rd_q;
    logic              load_ops;
    logic              wb;
    logic [XLEN-1:0]   regs [1:31];
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;

    // Instruction class decode from the held instruction
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_arith;
    logic       is_shift;
    logic       is_branch;

    assign opcode    = decinst[6:0];
    assign funct3    = decinst[9:7];
    assign is_arith  = (opcode == 7'b0010011) || (opcode == 7'b0110011);
    assign is_shift  = is_arith && ((funct3 == 3'b001) || (funct3 == 3'b101));
    assign is_branch = (opcode == 7'b1100011);

    // Register file read ports; x0 is hardwired to zero
    assign rs1_val = (rs1_sel == '0) ? '0 : regs[rs1_sel];
    assign rs2_val = (rs2_sel == '0) ? '0 : regs[rs2_sel];

    // State and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state logic and one-cycle strobes
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        load_ops = 1'b0;
        wb       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    load_ops = 1'b1;
                end
            end
            S_LOAD: begin
                if (is_shift) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(ALU_LAT - 1);
                end
            end
            S_SHIFT: begin
                if (sl_ok) begin
                    if (OUT_LAT == 0) begin
                        state_d = S_WB;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CW'(OUT_LAT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_d = S_WB;
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end
            S_WB: begin
                state_d = S_IDLE;
                wb      = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered outputs; en/busy follow the next state so they align with it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs1     <= '0;
            rs2     <= '0;
            imm     <= '0;
            decinst <= '0;
            rd_q    <= '0;
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cmp_q   <= 1'b0;
        end else begin
            en   <= (state_d == S_SHIFT);
            busy <= (state_d != S_IDLE);
            done <= wb;
            if (load_ops) begin
                rs1     <= rs1_val;
                rs2     <= rs2_val;
                imm     <= imm_in;
                decinst <= decinst_in;
                rd_q    <= rd_sel;
            end else if (wb) begin
                // Zero instruction in IDLE tells the ALU to release rd
                decinst <= '0;
            end
            if (wb && is_branch) begin
                cmp_q <= cmp;
            end
        end
    end

    // Register file write-back
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb && is_arith && (rd_q != '0)) begin
            regs[rd_q] <= rd;
        end
    end

endmodule

// File: tb/tb_regfile_seq.sv
// Directed testbench for regfile_seq. The bench stands in for the ALU: it
// drives rd, cmp and sl_ok, and it reads registers back through an
// ILLEGAL-class operation that exposes regs[rs1_sel] on rs1.
module tb_regfile_seq;

    localparam int unsigned ALU_LAT = 2;
    localparam int unsigned OUT_LAT = 1;

    localparam logic [11:0] I_ADDI = 12'b000000010011;
    localparam logic [11:0] I_ADD  = 12'b000000110011;
    localparam logic [11:0] I_SLL  = 12'b000010010011;
    localparam logic [11:0] I_BNE  = 12'b000011100011;
    localparam logic [11:0] I_ILL  = 12'b000000000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] decinst_in;
    logic [4:0]  rs1_sel, rs2_sel, rd_sel;
    logic [31:0] imm_in;
    logic [31:0] rs1, rs2, imm;
    logic [11:0] decinst;
    logic        en;
    logic [31:0] rd;
    logic        sl_ok, cmp;
    logic        busy, done, cmp_q;

    int checks   = 0;
    int failures = 0;

    int          lat, enc, nd, k;
    logic [31:0] o1, o2, oi, v;
    logic [11:0] od;

    regfile_seq #(.ALU_LAT(ALU_LAT), .OUT_LAT(OUT_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .decinst_in (decinst_in),
        .rs1_sel    (rs1_sel),
        .rs2_sel    (rs2_sel),
        .rd_sel     (rd_sel),
        .imm_in     (imm_in),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm        (imm),
        .decinst    (decinst),
        .en         (en),
        .rd         (rd),
        .sl_ok      (sl_ok),
        .cmp        (cmp),
        .busy       (busy),
        .done       (done),
        .cmp_q      (cmp_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation; lat counts edges from the start-sampling edge to done.
    // sl_ok rises after sh_n cycles of en. With hold, start stays high while busy.
    task automatic run_op(input logic [11:0] inst, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d, input logic [31:0] immv, input logic [31:0] rdv,
                          input logic cmpv, input int sh_n, input bit hold,
                          output int lat_o, output int en_o, output int nd_o,
                          output logic [31:0] r1_o, output logic [31:0] r2_o,
                          output logic [31:0] imm_o, output logic [11:0] inst_o);
        decinst_in = inst;
        rs1_sel    = s1;
        rs2_sel    = s2;
        rd_sel     = d;
        imm_in     = immv;
        rd         = rdv;
        cmp        = cmpv;
        sl_ok      = 1'b0;
        start      = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        r1_o   = rs1;
        r2_o   = rs2;
        imm_o  = imm;
        inst_o = decinst;
        lat_o  = 0;
        en_o   = 0;
        nd_o   = 0;
        while (!done && lat_o < 60) begin
            if (en) begin
                en_o++;
                sl_ok = (en_o >= sh_n);
            end else begin
                sl_ok = 1'b0;
            end
            tick();
            lat_o++;
        end
        if (done) nd_o = 1;
        start = 1'b0;
        sl_ok = 1'b0;
        if (hold) begin
            repeat (3) begin
                tick();
                if (done) nd_o++;
            end
        end
    endtask

    task automatic read_reg(input logic [4:0] idx, output logic [31:0] val, output int lat_o);
        int          e, n;
        logic [31:0] a, b;
        logic [11:0] c;
        run_op(I_ILL, idx, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0, 0, 1'b0, lat_o, e, n, val, a, b, c);
    endtask

    task automatic wr_reg(input logic [4:0] idx, input logic [31:0] val, output int lat_o);
        int          e, n;
        logic [31:0] a, b, c;
        logic [11:0] dd;
        run_op(I_ADDI, 5'd0, 5'd0, idx, val, val, 1'b0, 0, 1'b0, lat_o, e, n, a, b, c, dd);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; decinst_in = '0;
        rs1_sel = '0; rs2_sel = '0; rd_sel = '0; imm_in = '0;
        rd = '0; sl_ok = 1'b0; cmp = 1'b0;

        // Reset state
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_decinst", 32'(decinst), 32'd0);
        chk("rst_rs1", rs1, 32'd0);
        chk("rst_cmp_q", 32'(cmp_q), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Prime x1=5, x2=7; first start right after reset release
        wr_reg(5'd1, 32'd5, lat);
        chk("first_start_lat", 32'(lat), 32'(ALU_LAT + 2));
        wr_reg(5'd2, 32'd7, lat);

        // ADD x3 = x1 + x2
        run_op(I_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'd12, 1'b0, 0, 1'b0, lat, enc, nd, o1, o2, oi, od);
        chk("add_rs1", o1, 32'd5);
        chk("add_rs2", o2, 32'd7);
        chk("add_decinst", 32'(od), 32'(I_ADD));
        chk("add_lat", 32'(lat), 32'(ALU_LAT + 2));
        chk("idle_decinst_zero", 32'(decinst), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        read_reg(5'd3, v, lat);
        chk("add_x3_backtoback", v, 32'd12);

        // SLL x4 = x1 << 8 with 3 shift cycles
        wr_reg(5'd1, 32'd1, lat);
        run_op(I_SLL, 5'd1, 5'd0, 5'd4, 32'd8, 32'h100, 1'b0, 3, 1'b0, lat, enc, nd, o1, o2, oi, od);
        chk("sll_rs1", o1, 32'd1);
        chk("sll_imm", oi, 32'd8);
        chk("sll_en_cycles", 32'(enc), 32'd3);
        chk("sll_lat", 32'(lat), 32'(3 + OUT_LAT + 2));
        read_reg(5'd4, v, lat);
        chk("sll_x4", v, 32'h100);

        // Branch: x1=x2=3, rd_sel=5 with junk on rd must not write
        wr_reg(5'd1, 32'd3, lat);
        wr_reg(5'd2, 32'd3, lat);
        run_op(I_BNE, 5'd1, 5'd2, 5'd5, 32'd0, 32'hDEAD, 1'b0, 0, 1'b0, lat, enc, nd, o1, o2, oi, od);
        chk("br0_cmp_q", 32'(cmp_q), 32'd0);
        chk("br0_rs1", o1, 32'd3);
        run_op(I_BNE, 5'd1, 5'd2, 5'd5, 32'd0, 32'hDEAD, 1'b1, 0, 1'b0, lat, enc, nd, o1, o2, oi, od);
        chk("br1_cmp_q", 32'(cmp_q), 32'd1);
        chk("br1_lat", 32'(lat), 32'(ALU_LAT + 2));
        read_reg(5'd5, v, lat);
        chk("br_x5_unwritten", v, 32'd0);
        chk("illegal_keeps_cmp_q", 32'(cmp_q), 32'd1);
        read_reg(5'd3, v, lat);
        chk("br_x3_unchanged", v, 32'd12);
        run_op(I_BNE, 5'd1, 5'd2, 5'd5, 32'd0, 32'hDEAD, 1'b0, 0, 1'b0, lat, enc, nd, o1, o2, oi, od);
        chk("br2_cmp_q", 32'(cmp_q), 32'd0);

        // Write to x0 with start held through the whole operation
        run_op(I_ADDI, 5'd0, 5'd0, 5'd0, 32'h55, 32'h55, 1'b0, 0, 1'b1, lat, enc, nd, o1, o2, oi, od);
        chk("busy_start_one_done", 32'(nd), 32'd1);
        chk("busy_start_idle", 32'(busy), 32'd0);
        read_reg(5'd0, v, lat);
        chk("x0_zero", v, 32'd0);

        // Reset asserted while in SHIFT
        decinst_in = I_SLL; rs1_sel = 5'd1; rs2_sel = 5'd0; rd_sel = 5'd6;
        imm_in = 32'd8; rd = 32'hBEEF; sl_ok = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!en && k < 10) begin
            tick();
            k++;
        end
        chk("abort_in_shift", 32'(en), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_en", 32'(en), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        nd = 0;
        repeat (6) begin
            tick();
            if (done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        read_reg(5'd6, v, lat);
        chk("abort_x6_unwritten", v, 32'd0);
        chk("post_reset_lat", 32'(lat), 32'(ALU_LAT + 2));
        read_reg(5'd1, v, lat);
        chk("reset_cleared_x1", v, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_seq.md
REGFILE_SEQ -- requirements
Module: regfile_seq

Interface
REQ-001 SHALL have parameter ALU_LAT, default 2: cycles from operands valid to ALU rd valid for non-shift operations (range 1-7).
REQ-002 SHALL have parameter OUT_LAT, default 1: cycles from sl_ok high to shifted rd valid (range 0-7).
REQ-003 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: execute request, sampled only in IDLE.
REQ-006 SHALL have port decinst_in, input, 12: {funct7[5], bit10, funct3, opcode} decoded instruction.
REQ-007 SHALL have ports rs1_sel, rs2_sel, rd_sel, input, 5 each: register indices.
REQ-008 SHALL have port imm_in, input, 32: immediate.
REQ-009 SHALL have ports rs1, rs2, imm, output, 32 each: registered ALU operands.
REQ-010 SHALL have port decinst, output, 12: registered instruction to the ALU.
REQ-011 SHALL have port en, output, 1: ALU shift enable.
REQ-012 SHALL have port rd, input, 32: ALU result bus; may be high-Z outside writeback.
REQ-013 SHALL have ports sl_ok and cmp, input, 1 each: ALU shift-done and branch-compare.
REQ-014 SHALL have ports busy, done and cmp_q, output, 1 each: operation in progress, one-cycle completion pulse, and latched branch result.

Function
REQ-015 SHALL hold 31 x 32-bit registers x1..x31; x0 SHALL read as 0, and writes to x0 SHALL be discarded.
REQ-016 SHALL classify: ARITH = opcode 0010011 or 0110011; SHIFT = ARITH with funct3 001 or 101; BRANCH = opcode 1100011; all else ILLEGAL.
REQ-017 SHALL implement states IDLE, LOAD, SHIFT, WAIT, WB.
REQ-018 IDLE: busy=0; on start=1, register decinst_in, rd_sel, imm_in, regs[rs1_sel] and regs[rs2_sel] into the outputs, then go to LOAD.
REQ-019 LOAD (1 cycle, en=0, so the ALU loads its shift registers): SHIFT goes to SHIFT; all other classes go to WAIT with counter=ALU_LAT-1.
REQ-020 SHIFT: en=1 until sl_ok=1; on sl_ok, go to WB if OUT_LAT=0, else go to WAIT with counter=OUT_LAT-1.
REQ-021 WAIT: decrement counter each cycle; at counter=0, go to WB.
REQ-022 WB (1 cycle): ARITH/SHIFT writes rd to regs[rd_sel] (x0 excepted); BRANCH sets cmp_q=cmp and writes nothing; ILLEGAL writes nothing and leaves cmp_q unchanged; done=1; next state IDLE.
REQ-023 busy SHALL be 1 in all states except IDLE; start while busy SHALL be ignored, with no queuing.
REQ-024 Operand, decinst and imm outputs SHALL stay stable from LOAD through WB; in IDLE, decinst SHALL be 0 so the ALU releases rd.
REQ-025 If rs1_sel or rs2_sel equals the rd_sel being written in WB, a start in the following IDLE cycle SHALL read the new value; there is no same-cycle bypass, because start is not sampled in WB.
REQ-026 Latency start to done SHALL be ALU_LAT+2 cycles for non-shift operations and shift_cycles+OUT_LAT+2 for shifts.

Reset
REQ-027 reset=0 SHALL immediately force IDLE and clear all registers, rs1, rs2, imm, decinst, counter, en, done, busy and cmp_q to 0.
REQ-028 reset asserted mid-operation SHALL abort it with no register write and no done pulse.
REQ-029 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-030 ADD: x1=5, x2=7, addi-style writes prime the registers; start add (000000110011) rd=3 with an ALU model of ALU_LAT=2 -> done 4 cycles after start, x3=12.
REQ-031 SLL: x1=1, imm=8, sllx (000010010011) rd=4 -> en high until sl_ok, x4=0x100, done OUT_LAT+1 cycles after sl_ok.
REQ-032 Branch: beq-class bne with x1=3, x2=3 and cmp=0 -> cmp_q=0, no register changed; repeat with cmp=1 -> cmp_q=1.
REQ-033 Write to x0 with rd=0x55 -> x0 still reads 0; start during busy -> ignored, only one done pulse.
REQ-034 Assert reset in the SHIFT state -> busy=0, en=0 immediately, destination register unchanged, and no done pulse.
